// File: rtl/nano_cache_line_mover.sv
//==============================================================================
// Module   : nano_cache_line_mover
// Purpose  : Memory-side line mover behind the NanoCore data cache. Turns a
//            line-granular request (refill read, victim write, write-back)
//            into eight in-order 32-bit beats on a single-port word SRAM and
//            returns refilled lines to the cache with a one-cycle pulse.
// Ports    : i_clk/i_rst_n        clock, async active-low reset
//            i_miss_*/o_miss_resp cache miss interface (level requests)
//            o_upd_valid/rdata    refill line return
//            i_wb_wren/o_wb_gnt   write-back pulse and same-cycle grant
//            o_mem_*/i_mem_*      SRAM beat interface
//            o_stat_*             acceptance counters (NANOCACHE_MOVER_STAT_EN)
// Options  : `define NANOCACHE_MOVER_STAT_EN to add the statistics outputs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nano_cache_line_mover #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MEM_AW          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_miss_rden,
    input  logic              i_miss_wren,
    input  logic [31:0]       i_miss_addr,
    input  logic [255:0]      i_miss_wdata,
    output logic              o_miss_resp,
    output logic              o_upd_valid,
    output logic [255:0]      o_upd_rdata,
    input  logic              i_wb_wren,
    output logic              o_wb_gnt,
    output logic              o_mem_rden,
    output logic              o_mem_wren,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
`ifdef NANOCACHE_MOVER_STAT_EN
    ,
    output logic [31:0]       o_stat_refill,
    output logic [31:0]       o_stat_victim,
    output logic [31:0]       o_stat_wb
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        UPD  = 2'd3
    } state_e;

    localparam logic [3:0] c_MAX_OUT    = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] c_LINE_BEATS = 4'd8;

    state_e         state_q, state_d;
    logic [3:0]     issued_q, issued_d;
    logic [3:0]     returned_q, returned_d;
    logic [26:0]    addr_q, addr_d;
    logic [255:0]   line_q, line_d;
    logic           resp_q, resp_d;

    logic           w_acc_rd;
    logic           w_acc_wr;
    logic           w_acc_wb;
    logic           w_rden;
    logic           w_wren;
    logic [31:0]    w_beat_addr;
    logic           w_unused_addr;

    // Upper line-address bits do not contribute to the byte address.
    assign w_unused_addr = ^i_miss_addr[31:27];

    //--------------------------------------------------------------------------
    // Next-state / datapath
    //--------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        addr_d     = addr_q;
        line_d     = line_q;
        resp_d     = 1'b0;
        w_acc_rd   = 1'b0;
        w_acc_wr   = 1'b0;
        w_acc_wb   = 1'b0;
        w_rden     = 1'b0;
        w_wren     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_miss_wren) begin
                    w_acc_wr   = 1'b1;
                    resp_d     = 1'b1;
                    addr_d     = i_miss_addr[26:0];
                    line_d     = i_miss_wdata;
                    issued_d   = 4'd0;
                    returned_d = 4'd0;
                    state_d    = WR;
                end else if (i_miss_rden) begin
                    w_acc_rd   = 1'b1;
                    resp_d     = 1'b1;
                    addr_d     = i_miss_addr[26:0];
                    line_d     = '0;
                    issued_d   = 4'd0;
                    returned_d = 4'd0;
                    state_d    = RD;
                end else if (i_wb_wren) begin
                    // Write-back shares the miss address/data bus but gets no resp.
                    w_acc_wb   = 1'b1;
                    addr_d     = i_miss_addr[26:0];
                    line_d     = i_miss_wdata;
                    issued_d   = 4'd0;
                    returned_d = 4'd0;
                    state_d    = WR;
                end
            end

            WR: begin
                w_wren = (issued_q < c_LINE_BEATS);
                if (w_wren && i_mem_gnt) begin
                    issued_d = issued_q + 4'd1;
                    // Writes are posted: leave as soon as the last beat is taken.
                    if (issued_q == c_LINE_BEATS - 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            RD: begin
                // Throttle on beats granted but not yet returned.
                w_rden = (issued_q < c_LINE_BEATS) &&
                         ((issued_q - returned_q) < c_MAX_OUT);
                if (w_rden && i_mem_gnt) begin
                    issued_d = issued_q + 4'd1;
                end
                // Stray rvalid with nothing outstanding is ignored.
                if (i_mem_rvalid && (returned_q != issued_q)) begin
                    line_d[{returned_q[2:0], 5'b00000} +: 32] = i_mem_rdata;
                    returned_d = returned_q + 4'd1;
                    if (returned_q == c_LINE_BEATS - 4'd1) begin
                        state_d = UPD;
                    end
                end
            end

            UPD: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            issued_q   <= 4'd0;
            returned_q <= 4'd0;
            addr_q     <= 27'd0;
            line_q     <= '0;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            resp_q     <= resp_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign o_miss_resp = resp_q;
    assign o_wb_gnt    = w_acc_wb;
    assign o_upd_valid = (state_q == UPD);
    assign o_upd_rdata = (state_q == UPD) ? line_q : '0;
    assign o_mem_rden  = w_rden;
    assign o_mem_wren  = w_wren;
    assign o_mem_wstrb = {4{w_wren}};
    assign o_mem_wdata = w_wren ? line_q[{issued_q[2:0], 5'b00000} +: 32] : 32'd0;

    assign w_beat_addr = (w_rden || w_wren) ? {addr_q, issued_q[2:0], 2'b00} : 32'd0;

    generate
        if (MEM_AW == 32) begin : g_addr_exact
            assign o_mem_addr = w_beat_addr;
        end else if (MEM_AW > 32) begin : g_addr_wide
            assign o_mem_addr = {{(MEM_AW - 32){1'b0}}, w_beat_addr};
        end else begin : g_addr_narrow
            logic w_unused_hi;
            assign w_unused_hi = ^w_beat_addr[31:MEM_AW];
            assign o_mem_addr  = w_beat_addr[MEM_AW-1:0];
        end
    endgenerate

`ifdef NANOCACHE_MOVER_STAT_EN
    //--------------------------------------------------------------------------
    // Acceptance statistics, free-running modulo 2^32
    //--------------------------------------------------------------------------
    logic [31:0] stat_refill_q, stat_refill_d;
    logic [31:0] stat_victim_q, stat_victim_d;
    logic [31:0] stat_wb_q,     stat_wb_d;

    always_comb begin
        stat_refill_d = stat_refill_q + {31'd0, w_acc_rd};
        stat_victim_d = stat_victim_q + {31'd0, w_acc_wr};
        stat_wb_d     = stat_wb_q     + {31'd0, w_acc_wb};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_refill_q <= 32'd0;
            stat_victim_q <= 32'd0;
            stat_wb_q     <= 32'd0;
        end else begin
            stat_refill_q <= stat_refill_d;
            stat_victim_q <= stat_victim_d;
            stat_wb_q     <= stat_wb_d;
        end
    end

    assign o_stat_refill = stat_refill_q;
    assign o_stat_victim = stat_victim_q;
    assign o_stat_wb     = stat_wb_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nano_cache_line_mover.sv
//==============================================================================
// Module   : tb_nano_cache_line_mover
// Purpose  : Self-checking bench for nano_cache_line_mover. A behavioural
//            SRAM responder grants beats, returns read data with a
//            programmable latency and checks beats against scoreboard queues.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nano_cache_line_mover;

    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_rden, miss_wren, wb_wren;
    logic [31:0]  miss_addr;
    logic [255:0] miss_wdata;
    logic         miss_resp, upd_valid, wb_gnt;
    logic [255:0] upd_rdata;
    logic         mem_rden, mem_wren, mem_gnt, mem_rvalid;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_wstrb;
`ifdef NANOCACHE_MOVER_STAT_EN
    logic [31:0]  stat_refill, stat_victim, stat_wb;
`endif

    always #5 clk = ~clk;

    nano_cache_line_mover #(.MAX_OUTSTANDING(MAXO), .MEM_AW(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_miss_rden  (miss_rden),
        .i_miss_wren  (miss_wren),
        .i_miss_addr  (miss_addr),
        .i_miss_wdata (miss_wdata),
        .o_miss_resp  (miss_resp),
        .o_upd_valid  (upd_valid),
        .o_upd_rdata  (upd_rdata),
        .i_wb_wren    (wb_wren),
        .o_wb_gnt     (wb_gnt),
        .o_mem_rden   (mem_rden),
        .o_mem_wren   (mem_wren),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wstrb  (mem_wstrb),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
`ifdef NANOCACHE_MOVER_STAT_EN
        ,
        .o_stat_refill(stat_refill),
        .o_stat_victim(stat_victim),
        .o_stat_wb    (stat_wb)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rlat   = 1;
    bit gnt_rand = 1'b0;
    int out_cnt = 0;
    int upd_cnt = 0;
    int resp_cnt = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  exp_rd_q   [$];
    logic [63:0]  exp_wr_q   [$];
    logic [255:0] exp_line_q [$];
    pend_t        pend_q     [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    //--------------------------------------------------------------------------
    // SRAM responder and output scoreboard (works on the falling edge)
    //--------------------------------------------------------------------------
    always @(negedge clk) begin
        logic        g;
        logic [63:0] ew;
        logic [31:0] ea;
        logic [255:0] el;
        pend_t       p;
        if (!rst_n) begin
            pend_q.delete();
            out_cnt    = 0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end else begin
            if (mem_rden) begin
                checks++;
                if (out_cnt >= MAXO) begin
                    errors++;
                    $display("FAIL outstanding: %0d already outstanding, limit %0d", out_cnt, MAXO);
                end
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p          = pend_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = p.data;
                out_cnt--;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'd0;
            end
            g = (mem_rden || mem_wren) && (!gnt_rand || ($urandom_range(0, 1) == 1));
            mem_gnt = g;
            if (g && mem_wren) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_beat: unexpected write addr %h data %h", mem_addr, mem_wdata);
                end else begin
                    ew = exp_wr_q.pop_front();
                    if ({mem_addr, mem_wdata} !== ew || mem_wstrb !== 4'hf) begin
                        errors++;
                        $display("FAIL wr_beat: got addr %h data %h strb %h, expected addr %h data %h strb f",
                                 mem_addr, mem_wdata, mem_wstrb, ew[63:32], ew[31:0]);
                    end
                end
                mem[mem_addr] = mem_wdata;
            end
            if (g && mem_rden) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_beat: unexpected read addr %h", mem_addr);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (mem_addr !== ea || mem_wstrb !== 4'h0) begin
                        errors++;
                        $display("FAIL rd_beat: got addr %h strb %h, expected addr %h strb 0",
                                 mem_addr, mem_wstrb, ea);
                    end
                end
                p.due  = cyc + rlat;
                p.data = mem_rd(mem_addr);
                pend_q.push_back(p);
                out_cnt++;
            end
            if (upd_valid) begin
                upd_cnt++;
                checks++;
                if (exp_line_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_line: unexpected update %h", upd_rdata);
                end else begin
                    el = exp_line_q.pop_front();
                    if (upd_rdata !== el) begin
                        errors++;
                        $display("FAIL upd_line: got %h expected %h", upd_rdata, el);
                    end
                end
            end
            if (miss_resp) resp_cnt++;
        end
    end

    //--------------------------------------------------------------------------
    // Helpers (stimulus only)
    //--------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_refill(input logic [31:0] line_addr);
        logic [255:0] l;
        logic [31:0]  a;
        for (int i = 0; i < 8; i++) begin
            a = {line_addr[26:0], 5'b0} + 32'(i * 4);
            exp_rd_q.push_back(a);
            l[i*32 +: 32] = mem_rd(a);
        end
        exp_line_q.push_back(l);
    endtask

    task automatic wait_line(input int maxc, output int n);
        n = 0;
        while (exp_line_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        miss_rden = 0; miss_wren = 0; wb_wren = 0;
        miss_addr = 0; miss_wdata = '0;
        repeat (3) tick();
        checks++;
        if ({miss_resp, upd_valid, wb_gnt, mem_rden, mem_wren} !== 5'b0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 || upd_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: resp %b upd %b gnt %b rden %b wren %b addr %h wdata %h, all required 0",
                     miss_resp, upd_valid, wb_gnt, mem_rden, mem_wren, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({miss_resp, mem_rden, mem_wren, upd_valid} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: resp %b rden %b wren %b upd %b, required 0",
                     miss_resp, mem_rden, mem_wren, upd_valid);
        end
    endtask

    task automatic test_refill();
        logic [255:0] l;
        int n;
        for (int i = 0; i < 8; i++) begin
            mem[32'h2460 + 32'(i * 4)] = 32'(i);
            exp_rd_q.push_back(32'h2460 + 32'(i * 4));
            l[i*32 +: 32] = 32'(i);
        end
        exp_line_q.push_back(l);
        miss_addr = 32'h0000_0123;
        miss_rden = 1'b1;
        tick();
        checks++;
        if (miss_resp !== 1'b1) begin
            errors++;
            $display("FAIL refill_resp: got %b required 1", miss_resp);
        end
        miss_rden = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (upd_valid) break;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL refill_latency: upd after %0d cycles past resp, required 9", n);
        end
        tick();
        checks++;
        if (exp_rd_q.size() != 0 || exp_line_q.size() != 0 || resp_cnt != 1) begin
            errors++;
            $display("FAIL refill_drain: rd left %0d line left %0d resp count %0d, required 0/0/1",
                     exp_rd_q.size(), exp_line_q.size(), resp_cnt);
        end
    endtask

    task automatic test_victim_then_read();
        logic [255:0] l;
        int n;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = 32'hA0 + 32'(i);
            exp_wr_q.push_back({32'h800 + 32'(i * 4), 32'hA0 + 32'(i)});
        end
        miss_addr  = 32'h40;
        miss_wdata = l;
        miss_wren  = 1'b1;
        tick();
        checks++;
        if (miss_resp !== 1'b1) begin
            errors++;
            $display("FAIL victim_resp: got %b required 1", miss_resp);
        end
        miss_wren  = 1'b0;
        miss_wdata = '0;
        miss_rden  = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd_q.push_back(32'h800 + 32'(i * 4));
        exp_line_q.push_back(l);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (miss_resp) break;
        end
        checks++;
        if (n != 9 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL write_then_read: read resp after %0d cycles with %0d writes pending, required 9 and 0",
                     n, exp_wr_q.size());
        end
        miss_rden = 1'b0;
        wait_line(40, n);
        checks++;
        if (exp_line_q.size() != 0) begin
            errors++;
            $display("FAIL victim_readback: line not returned within %0d cycles, required return", n);
        end
        tick();
    endtask

    task automatic test_wb_collision();
        int n;
        miss_addr = 32'h200;
        miss_wdata = {8{32'hDEAD_BEEF}};
        wb_wren   = 1'b1;
        miss_rden = 1'b1;
        push_refill(32'h200);
        #1;
        checks++;
        if (wb_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wb_lose_arb: o_wb_gnt %b required 0", wb_gnt);
        end
        tick();
        wb_wren = 1'b0;
        checks++;
        if (miss_resp !== 1'b1) begin
            errors++;
            $display("FAIL wb_collision_resp: got %b required 1", miss_resp);
        end
        miss_rden = 1'b0;
        wait_line(40, n);
        checks++;
        if (exp_line_q.size() != 0) begin
            errors++;
            $display("FAIL wb_collision_read: line not returned within %0d cycles", n);
        end
        tick();
    endtask

    task automatic test_wb_grant();
        logic [255:0] l;
        int r0;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = 32'hB0 + 32'(i);
            exp_wr_q.push_back({32'h6000 + 32'(i * 4), 32'hB0 + 32'(i)});
        end
        r0 = resp_cnt;
        miss_addr  = 32'h300;
        miss_wdata = l;
        wb_wren    = 1'b1;
        #1;
        checks++;
        if (wb_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wb_grant: o_wb_gnt %b required 1", wb_gnt);
        end
        tick();
        wb_wren    = 1'b0;
        miss_wdata = '0;
        repeat (12) tick();
        checks++;
        if (exp_wr_q.size() != 0 || resp_cnt != r0) begin
            errors++;
            $display("FAIL wb_writes: %0d writes pending, %0d resp pulses, required 0 and 0",
                     exp_wr_q.size(), resp_cnt - r0);
        end
    endtask

    task automatic test_slow_sram();
        int n, u0;
        rlat     = 3;
        gnt_rand = 1'b1;
        u0 = upd_cnt;
        push_refill(32'h77);
        miss_addr = 32'h77;
        miss_rden = 1'b1;
        tick();
        checks++;
        if (miss_resp !== 1'b1) begin
            errors++;
            $display("FAIL slow_resp: got %b required 1", miss_resp);
        end
        miss_rden = 1'b0;
        wait_line(300, n);
        repeat (6) tick();
        checks++;
        if (exp_line_q.size() != 0 || upd_cnt != u0 + 1) begin
            errors++;
            $display("FAIL slow_refill: %0d lines pending, %0d updates, required 0 and 1",
                     exp_line_q.size(), upd_cnt - u0);
        end
        rlat     = 1;
        gnt_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, u0, r0;
        push_refill(32'h123);
        miss_addr = 32'h123;
        miss_rden = 1'b1;
        tick();
        miss_rden = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({miss_resp, upd_valid, wb_gnt, mem_rden, mem_wren} !== 5'b0 ||
            mem_addr !== 32'd0 || upd_rdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: resp %b upd %b rden %b wren %b addr %h, required 0",
                     miss_resp, upd_valid, mem_rden, mem_wren, mem_addr);
        end
        exp_rd_q.delete();
        exp_line_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        u0 = upd_cnt;
        r0 = resp_cnt;
        repeat (15) tick();
        checks++;
        if (upd_cnt != u0 || resp_cnt != r0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d updates %0d resps after release, required 0 and 0",
                     upd_cnt - u0, resp_cnt - r0);
        end
        push_refill(32'h123);
        miss_rden = 1'b1;
        tick();
        checks++;
        if (miss_resp !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_resp: got %b required 1", miss_resp);
        end
        miss_rden = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (upd_valid) break;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL post_reset_refill: upd after %0d cycles past resp, required 9", n);
        end
        tick();
    endtask

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_refill();
        test_victim_then_read();
        test_wb_collision();
        test_wb_grant();
        test_slow_sram();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/nano_cache_line_mover.md
Name: nano_cache_line_mover

Overview:
- Memory-side line mover placed directly downstream of the NanoCore data cache.
- Takes the cache's line-granular requests: miss refill read, dirty-victim write, and idle-time write-back.
- Converts each 8x32-bit line transfer into eight sequential 32-bit beats on a single-port word SRAM interface.
- Returns the refill line to the cache with a one-cycle update pulse.

Parameters:
MAX_OUTSTANDING, 2, max read beats granted by SRAM but not yet returned (1..8)
MEM_AW, 32, SRAM byte-address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_miss_rden  in  1  refill-read request, level, held until o_miss_resp
i_miss_wren  in  1  victim-write request, level, held until o_miss_resp
i_miss_addr  in  32  line address; bits [26:0] = byte address >> 5
i_miss_wdata  in  8x32  line data for victim-write / write-back
o_miss_resp  out  1  request accepted pulse
o_upd_valid  out  1  refill line valid pulse
o_upd_rdata  out  8x32  refill line
i_wb_wren  in  1  write-back request, single-cycle pulse, shares i_miss_addr/i_miss_wdata
o_wb_gnt  out  1  write-back accepted (combinational)
o_mem_rden  out  1  SRAM read beat request
o_mem_wren  out  1  SRAM write beat request
o_mem_addr  out  MEM_AW  byte address of beat
o_mem_wdata  out  32  write beat data
o_mem_wstrb  out  4  always 4'hf on writes, 0 on reads
i_mem_gnt  in  1  beat accepted this cycle
i_mem_rvalid  in  1  read data valid, in issue order
i_mem_rdata  in  32  read data

Behaviour:
- Clock/reset: one clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - all outputs 0, o_upd_rdata 0.
  - FSM in IDLE; issue/return counters 0.
- FSM states: IDLE, RD, WR, UPD.
- IDLE acceptance priority: i_miss_wren > i_miss_rden > i_wb_wren. At most one request accepted per cycle.
  - miss accept: latch line address (and line data for wren) into internal registers; o_miss_resp=1 the next cycle for exactly one cycle.
  - Go to WR (wren) or RD (rden).
  - wb accept: o_wb_gnt = i_wb_wren & IDLE & ~i_miss_rden & ~i_miss_wren, same cycle; latch address+data; go to WR; no o_miss_resp.
  - i_wb_wren outside IDLE or losing arbitration: o_wb_gnt=0, request dropped; the cache re-pulses.
- Beat address: o_mem_addr = {i_miss_addr[26:0], beat[2:0], 2'b00}, truncated/zero-extended to MEM_AW. Beats are issued in order 0..7.
- WR:
  - o_mem_wren=1 with beat word until i_mem_gnt; issue counter increments on each gnt.
  - After the 8th gnt, return to IDLE next cycle (posted writes).
- RD:
  - o_mem_rden=1 while issued<8 and (issued - returned) < MAX_OUTSTANDING.
  - Each i_mem_rvalid stores i_mem_rdata into word[returned] and increments returned.
  - When returned reaches 8, go to UPD.
- UPD: o_upd_valid=1 for one cycle with the complete line; then IDLE.
- Re-acceptance: o_miss_resp is registered, so a held request is not re-accepted (FSM already left IDLE).
- Minimum latencies (zero-wait SRAM, gnt every cycle, rvalid 1 cycle after gnt):
  - refill: accept -> o_upd_valid = 10 cycles.
  - write: accept -> back to IDLE = 9 cycles.
- Write-then-read: a victim write followed immediately by a refill rden is accepted only after WR completes. The read therefore observes the written data.
- Protocol violations (undefined input, no recovery required):
  - i_mem_rvalid while returned==issued is ignored.
  - i_mem_rvalid outside RD is ignored.
- Counters are 4 bits and never wrap; a beat counter saturates at 8.
- Reset mid-operation: transfer abandoned, no o_upd_valid and no o_miss_resp afterwards, partial line discarded.

Optional Feature:
NANOCACHE_MOVER_STAT_EN:
- When defined, adds three 32-bit outputs: o_stat_refill, o_stat_victim, o_stat_wb.
  - Each increments on acceptance of its request type.
  - Each wraps modulo 2^32 and resets to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Refill, zero-wait SRAM, i_miss_addr=32'h0000_0123, rdata=beat index:
  - o_mem_addr steps 0x2460..0x247C.
  - o_miss_resp 1 cycle after accept.
  - o_upd_valid at cycle 10 with words 0..7.
- Victim write of line 32'h40, data 0xA0..0xA7, then rden held the cycle after resp:
  - 8 writes to 0x800..0x81C with wstrb 4'hf.
  - Read is accepted only after the 8th gnt.
- i_wb_wren and i_miss_rden in the same IDLE cycle -> o_wb_gnt=0, read accepted.
- Later wb pulse while IDLE -> o_wb_gnt=1 same cycle; 8 writes; no o_miss_resp.
- MAX_OUTSTANDING=2, rvalid returned 3 cycles after gnt:
  - never more than 2 reads outstanding.
  - line returned in order, o_upd_valid exactly once.
- Assert i_rst_n low after beat 4 of a refill:
  - all outputs 0 within the reset.
  - no o_upd_valid after release.
  - a new rden is then accepted normally.
